mod_counter_prescaled: RTL and testbench
========================================

# mod_counter_prescaled

Parametrised modulo-N up/down counter with an integrated tick prescaler. It replaces the fixed 8-bit counter plus free-running divider pair used for LED display labs. One module derives a count-enable tick from CLK_50M, steps a WIDTH-bit value modulo a runtime limit in either direction, and supports synchronous load and pause. Its output drives the LED array directly and exposes tick/wrap pulses for cascading digits.

## Interface
Parameters:
- WIDTH, 8: counter width in bits (1..32).
- DIV_WIDTH, 30: prescaler width in bits.

Ports:
- CLK_50M  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- period  in  DIV_WIDTH  prescaler terminal count, in CLK_50M cycles per tick. 0 is treated as 1.
- limit  in  WIDTH  modulus. Count range is 0..limit-1. 0 means modulus 2^WIDTH.
- en  in  1  run enable. When low, prescaler and counter freeze.
- up_down  in  1  direction: 1 counts up, 0 counts down.
- load  in  1  synchronous load strobe.
- load_value  in  WIDTH  value written on load.
- LED  out  WIDTH  current count, registered.
- tick  out  1  one-cycle pulse on every prescaler expiry, registered.
- wrap  out  1  one-cycle pulse when the count wraps, registered.

## Operation
- Priority per edge: RST > load > (en and tick step) > hold.
- Reset: prescaler=0, LED=0, tick=0, wrap=0.
- Prescaler:
  - Counter p increments while en=1.
  - When p >= eff_period-1, next p=0 and tick=1 for that cycle. eff_period = max(period,1).
  - The comparison uses >=, so lowering period mid-count causes expiry on the next enabled cycle.
  - en=0: p holds and tick=0.
- Step, applied on the same edge that sets tick:
  - Up mode: if LED >= lim-1, then LED=0 and wrap=1; otherwise LED+1.
  - Down mode: if LED==0, then LED=lim-1 and wrap=1. If LED > lim-1 (limit lowered), then LED=lim-1 with wrap=0. Otherwise LED-1.
  - lim is limit, widened to WIDTH+1 bits with 0 mapped to 2^WIDTH. All comparisons use WIDTH+1 bits, so no overflow occurs at the full modulus.
- Load:
  - LED=load_value verbatim, even if >= lim; p=0, tick=0, wrap=0.
  - A subsequent up step from an out-of-range value wraps to 0 with wrap=1.
- limit=1: LED stays 0 and wrap pulses on every tick.
- up_down and limit are sampled per step; changing them mid-count takes effect at the next step.

## Timing
- Tick spacing is exactly eff_period cycles under continuous en.
  - First tick after reset or load: edge number eff_period, counting the first enabled edge as edge 1.
- LED, tick and wrap all update on the same edge. Zero extra latency between tick and LED change.
- wrap is only ever high in a cycle where tick is high (load forces both low).
- RST asserted mid-count: all outputs are 0 on the next edge, regardless of en or load.
- Deasserting en for k cycles delays all subsequent ticks by exactly k cycles.

## Structure
- Shared package counter_pkg:
  - PERIOD_1HZ = 50_000_000.
  - PERIOD_10HZ = 5_000_000.
  - Default DIV_WIDTH.
  - Direction constants DIR_UP=1, DIR_DOWN=0.
- Sub-module tick_prescaler (CLK_50M, RST, en, clear, period -> tick). It holds p and the expiry compare. The top-level module contains the modulo step logic and the load mux.
- No other hierarchy.

## Test plan
- RST 3 cycles; WIDTH=8, period=4, limit=10, up, en=1 for 50 cycles -> tick every 4th cycle; LED 0..9 then 0; wrap=1 exactly on the 9->0 edge.
- period=1, limit=0, down, 3 cycles from reset -> LED 255, 254, 253; wrap on the first edge (0->255); tick every cycle.
- load_value=200 with limit=10, up, period=2 -> LED=200 after load; next tick gives LED=0, wrap=1.
- Lower limit 10->5 with LED=8 in down mode -> next tick gives LED=4, wrap=0.
- en low for 7 cycles mid-count with period=4 -> LED holds, tick=0; the following tick occurs 7 cycles later than without the pause.
- load and RST asserted together -> LED=0, tick=0, wrap=0; then RST alone at p=2 -> prescaler restarts, first tick after period cycles.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants for the prescaled modulo counter family.
package counter_pkg;

   // Prescaler terminal counts for a 50 MHz system clock.
   localparam int unsigned PERIOD_1HZ    = 50_000_000;
   localparam int unsigned PERIOD_10HZ   = 5_000_000;

   // 30 bits comfortably covers PERIOD_1HZ.
   localparam int unsigned DIV_WIDTH_DEF = 30;

   // Values of the up_down input.
   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/mod_counter_prescaled_tick_prescaler.sv
// Tick prescaler: counts enabled cycles and fires once every max(period,1) of them.
import counter_pkg::*;

module tick_prescaler #(
   parameter int unsigned DIV_WIDTH = DIV_WIDTH_DEF
) (
   input  logic                 CLK_50M,
   input  logic                 RST,
   input  logic                 en,
   input  logic                 clear,
   input  logic [DIV_WIDTH-1:0] period,
   output logic                 expire,
   output logic                 tick
);

   logic [DIV_WIDTH-1:0] r_p;
   logic                 r_tick;
   logic [DIV_WIDTH-1:0] w_eff;
   logic [DIV_WIDTH-1:0] w_term;

   // A period of 0 behaves like 1 so the prescaler can never stall.
   assign w_eff  = (period == '0) ? DIV_WIDTH'(1) : period;
   assign w_term = w_eff - DIV_WIDTH'(1);

   // Expiry uses >= so that lowering the period mid-count fires on the next
   // enabled cycle instead of running all the way round the counter.
   assign expire = en && !clear && (r_p >= w_term);
   assign tick   = r_tick;

   // Prescaler count and registered tick pulse; clear (load) restarts the count.
   always_ff @(posedge CLK_50M) begin
      if (RST || clear) begin
         r_p    <= '0;
         r_tick <= 1'b0;
      end else if (en) begin
         if (expire) begin
            r_p    <= '0;
            r_tick <= 1'b1;
         end else begin
            r_p    <= r_p + DIV_WIDTH'(1);
            r_tick <= 1'b0;
         end
      end else begin
         r_tick <= 1'b0;
      end
   end

endmodule

// File: rtl/mod_counter_prescaled.sv
// Modulo-N up/down counter stepped by an integrated tick prescaler.
import counter_pkg::*;

module mod_counter_prescaled #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned DIV_WIDTH = DIV_WIDTH_DEF
) (
   input  logic                 CLK_50M,
   input  logic                 RST,
   input  logic [DIV_WIDTH-1:0] period,
   input  logic [WIDTH-1:0]     limit,
   input  logic                 en,
   input  logic                 up_down,
   input  logic                 load,
   input  logic [WIDTH-1:0]     load_value,
   output logic [WIDTH-1:0]     LED,
   output logic                 tick,
   output logic                 wrap
);

   logic [WIDTH-1:0] r_led;
   logic             r_wrap;
   logic             w_expire;
   logic [WIDTH:0]   w_lim;
   logic [WIDTH:0]   w_lim_m1;
   logic [WIDTH:0]   w_led_ext;

   tick_prescaler #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_prescaler (
      .CLK_50M (CLK_50M),
      .RST     (RST),
      .en      (en),
      .clear   (load),
      .period  (period),
      .expire  (w_expire),
      .tick    (tick)
   );

   // Modulus in WIDTH+1 bits: limit 0 means the full 2^WIDTH range, and the
   // extra bit keeps lim-1 and the compares free of overflow.
   assign w_lim     = (limit == '0) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, limit};
   assign w_lim_m1  = w_lim - {{WIDTH{1'b0}}, 1'b1};
   assign w_led_ext = {1'b0, r_led};

   // Count register with load mux and modulo step on the prescaler expiry edge.
   always_ff @(posedge CLK_50M) begin
      if (RST) begin
         r_led  <= '0;
         r_wrap <= 1'b0;
      end else if (load) begin
         // Loaded verbatim, even out of range; the next up step wraps it.
         r_led  <= load_value;
         r_wrap <= 1'b0;
      end else if (w_expire) begin
         if (up_down == DIR_UP) begin
            if (w_led_ext >= w_lim_m1) begin
               r_led  <= '0;
               r_wrap <= 1'b1;
            end else begin
               r_led  <= r_led + WIDTH'(1);
               r_wrap <= 1'b0;
            end
         end else begin
            if (r_led == '0) begin
               r_led  <= w_lim_m1[WIDTH-1:0];
               r_wrap <= 1'b1;
            end else if (w_led_ext > w_lim_m1) begin
               // Limit was lowered below the count: clamp without a wrap.
               r_led  <= w_lim_m1[WIDTH-1:0];
               r_wrap <= 1'b0;
            end else begin
               r_led  <= r_led - WIDTH'(1);
               r_wrap <= 1'b0;
            end
         end
      end else begin
         r_wrap <= 1'b0;
      end
   end

   assign LED  = r_led;
   assign wrap = r_wrap;

endmodule

// File: tb/tb_mod_counter_prescaled.sv
// Scoreboard bench for mod_counter_prescaled (WIDTH=8, DIV_WIDTH=30).
module tb_mod_counter_prescaled;

   logic        CLK_50M = 1'b0;
   logic        RST = 1'b1;
   logic [29:0] period = 30'd4;
   logic [7:0]  limit = 8'd10;
   logic        en = 1'b0;
   logic        up_down = 1'b1;
   logic        load = 1'b0;
   logic [7:0]  load_value = 8'd0;
   logic [7:0]  LED;
   logic        tick;
   logic        wrap;

   typedef struct {
      logic [7:0] led;
      logic       tk;
      logic       wr;
      string      name;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   bit   done     = 1'b0;

   mod_counter_prescaled #(.WIDTH(8), .DIV_WIDTH(30)) dut (
      .CLK_50M    (CLK_50M),
      .RST        (RST),
      .period     (period),
      .limit      (limit),
      .en         (en),
      .up_down    (up_down),
      .load       (load),
      .load_value (load_value),
      .LED        (LED),
      .tick       (tick),
      .wrap       (wrap)
   );

   always #10 CLK_50M = ~CLK_50M;

   // Monitor: every clock edge produces an output triple; compare it to the
   // expectation queued for that edge.
   always @(posedge CLK_50M) begin
      #1;
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         checks++;
         if (LED !== e.led || tick !== e.tk || wrap !== e.wr) begin
            failures++;
            $display("FAIL %s: got LED=%0d tick=%0b wrap=%0b, want LED=%0d tick=%0b wrap=%0b",
                     e.name, LED, tick, wrap, e.led, e.tk, e.wr);
         end
      end
   end

   // Drive one cycle of inputs (at negedge) and queue the result expected
   // after the following rising edge.
   task automatic cyc(input logic rst_i, input logic ld, input logic e,
                      input logic ud, input logic [29:0] per,
                      input logic [7:0] lim, input logic [7:0] lv,
                      input logic [7:0] eled, input logic etk,
                      input logic ewr, input string nm);
      exp_t x;
      @(negedge CLK_50M);
      RST = rst_i; load = ld; en = e; up_down = ud;
      period = per; limit = lim; load_value = lv;
      x.led = eled; x.tk = etk; x.wr = ewr; x.name = nm;
      exp_q.push_back(x);
   endtask

   initial begin
      int q;
      bit t;
      // Reset state, 3 cycles.
      for (int i = 0; i < 3; i++) cyc(1, 0, 1, 1, 4, 10, 0, 0, 0, 0, "reset");

      // period=4, limit=10, up: tick every 4th edge, LED 0..9 then 0.
      for (int n = 1; n <= 50; n++) begin
         t = (n % 4 == 0);
         q = n / 4;
         cyc(0, 0, 1, 1, 4, 10, 0, 8'(q % 10), t, t && (q == 10), "up_p4_l10");
      end

      // period=1, full modulus, down from reset.
      cyc(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, "reset2");
      cyc(0, 0, 1, 0, 1, 0, 0, 255, 1, 1, "down_full_0");
      cyc(0, 0, 1, 0, 1, 0, 0, 254, 1, 0, "down_full_1");
      cyc(0, 0, 1, 0, 1, 0, 0, 253, 1, 0, "down_full_2");

      // Full-modulus up wrap 255 -> 0.
      cyc(0, 1, 1, 1, 1, 0, 255, 255, 0, 0, "load255");
      cyc(0, 0, 1, 1, 1, 0, 0, 0, 1, 1, "up_full_wrap");
      cyc(0, 0, 1, 1, 1, 0, 0, 1, 1, 0, "up_full_next");

      // Out-of-range load, then up step wraps.
      cyc(0, 1, 1, 1, 2, 10, 200, 200, 0, 0, "load200");
      cyc(0, 0, 1, 1, 2, 10, 0, 200, 0, 0, "oor_hold");
      cyc(0, 0, 1, 1, 2, 10, 0, 0, 1, 1, "oor_wrap");

      // LED=8, lower limit to 5 in down mode: clamp to 4 without wrap.
      cyc(0, 1, 1, 0, 2, 10, 8, 8, 0, 0, "load8");
      cyc(0, 0, 1, 0, 2, 5, 0, 8, 0, 0, "clamp_hold");
      cyc(0, 0, 1, 0, 2, 5, 0, 4, 1, 0, "clamp");
      cyc(0, 0, 1, 0, 2, 5, 0, 4, 0, 0, "clamp_hold2");
      cyc(0, 0, 1, 0, 2, 5, 0, 3, 1, 0, "down_after_clamp");

      // Pause: two enabled cycles, 7 disabled, then the tick lands 7 late.
      cyc(0, 1, 1, 1, 4, 10, 0, 0, 0, 0, "load0");
      cyc(0, 0, 1, 1, 4, 10, 0, 0, 0, 0, "pre_pause1");
      cyc(0, 0, 1, 1, 4, 10, 0, 0, 0, 0, "pre_pause2");
      for (int i = 0; i < 7; i++) cyc(0, 0, 0, 1, 4, 10, 0, 0, 0, 0, "paused");
      cyc(0, 0, 1, 1, 4, 10, 0, 0, 0, 0, "post_pause3");
      cyc(0, 0, 1, 1, 4, 10, 0, 1, 1, 0, "post_pause_tick");
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 4, 10, 0, 1, 0, 0, "post_gap");
      cyc(0, 0, 1, 1, 4, 10, 0, 2, 1, 0, "post_tick2");

      // Lower period mid-count: p=3 with period 8, drop to 2 -> expire next.
      cyc(0, 1, 1, 1, 8, 10, 0, 0, 0, 0, "load0b");
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 8, 10, 0, 0, 0, 0, "p8_run");
      cyc(0, 0, 1, 1, 2, 10, 0, 1, 1, 0, "period_drop");

      // limit=1: LED stays 0, wrap on every tick.
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 1, 1, 0, 0, 1, 1, "limit1");

      // period=0 behaves as 1.
      cyc(0, 0, 1, 1, 0, 10, 0, 1, 1, 0, "period0");

      // Load + RST together: reset wins.
      cyc(1, 1, 1, 1, 4, 10, 77, 0, 0, 0, "rst_and_load");
      cyc(0, 0, 1, 1, 4, 10, 0, 0, 0, 0, "pre_rst1");
      cyc(0, 0, 1, 1, 4, 10, 0, 0, 0, 0, "pre_rst2");
      cyc(1, 0, 1, 1, 4, 10, 0, 0, 0, 0, "rst_mid");
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 4, 10, 0, 0, 0, 0, "restart_gap");
      cyc(0, 0, 1, 1, 4, 10, 0, 1, 1, 0, "restart_tick");

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge CLK_50M);
      @(posedge CLK_50M);
      #2;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      done = 1'b1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog.
   initial begin
      #2_000_000;
      if (!done) begin
         $display("FAIL watchdog: bench did not finish, want finish");
         $fatal(1, "watchdog");
      end
   end

endmodule
